// File: rtl/panel_receiver.sv
// Three-channel serial LED panel receiver: shifts MSB-first frames and commits
// them on latch either as LED values or as a brightness setting.
module panel_receiver #(
  parameter int WIDTH       = 16,
  parameter int BRIGHT_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift,
  input  logic                         latch,
  input  logic                         sel_brightness,
  input  logic                         serial_data_in_red,
  input  logic                         serial_data_in_green,
  input  logic                         serial_data_in_blue,
  output logic [WIDTH-1:0]             vals_red,
  output logic [WIDTH-1:0]             vals_green,
  output logic [WIDTH-1:0]             vals_blue,
  output logic [BRIGHT_BITS-1:0]       brightness,
  output logic                         vals_valid,
  output logic                         bright_valid,
  output logic                         frame_err,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RECV, FULL, OVER} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [WIDTH-1:0]       red_reg, green_reg, blue_reg;
  logic [WIDTH-1:0]       red_next, green_next, blue_next;
  logic [WIDTH-1:0]       vals_red_next, vals_green_next, vals_blue_next;
  logic [BRIGHT_BITS-1:0] brightness_next;
  logic                   vals_valid_next, bright_valid_next, frame_err_next;

  assign bit_count = count_reg;

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    red_next          = red_reg;
    green_next        = green_reg;
    blue_next         = blue_reg;
    vals_red_next     = vals_red;
    vals_green_next   = vals_green;
    vals_blue_next    = vals_blue;
    brightness_next   = brightness;
    vals_valid_next   = 1'b0;
    bright_valid_next = 1'b0;
    frame_err_next    = frame_err;

    if (shift) begin
      red_next   = {red_reg[WIDTH-2:0], serial_data_in_red};
      green_next = {green_reg[WIDTH-2:0], serial_data_in_green};
      blue_next  = {blue_reg[WIDTH-2:0], serial_data_in_blue};
      case (state_reg)
        IDLE, RECV: begin
          count_next = count_reg + CW'(1);
          state_next = (count_next == FULL_COUNT) ? FULL : RECV;
        end
        FULL:    state_next = OVER;
        OVER:    state_next = OVER;
        default: state_next = IDLE;
      endcase
    end

    // The latch judges the frame as it stands after any same-cycle shift.
    if (latch) begin
      if (state_next == FULL && !sel_brightness) begin
        vals_red_next   = red_next;
        vals_green_next = green_next;
        vals_blue_next  = blue_next;
        vals_valid_next = 1'b1;
      end else if (state_next == FULL && (red_next >> BRIGHT_BITS) == '0) begin
        brightness_next   = red_next[BRIGHT_BITS-1:0];
        bright_valid_next = 1'b1;
      end else begin
        frame_err_next = 1'b1;
      end
      red_next   = '0;
      green_next = '0;
      blue_next  = '0;
      count_next = '0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      red_reg      <= '0;
      green_reg    <= '0;
      blue_reg     <= '0;
      vals_red     <= '0;
      vals_green   <= '0;
      vals_blue    <= '0;
      brightness   <= '0;
      vals_valid   <= 1'b0;
      bright_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      red_reg      <= red_next;
      green_reg    <= green_next;
      blue_reg     <= blue_next;
      vals_red     <= vals_red_next;
      vals_green   <= vals_green_next;
      vals_blue    <= vals_blue_next;
      brightness   <= brightness_next;
      vals_valid   <= vals_valid_next;
      bright_valid <= bright_valid_next;
      frame_err    <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_panel_receiver.sv
// Self-checking bench for panel_receiver: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_panel_receiver;

  localparam int W  = 16;
  localparam int BB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1, shift = 1'b0, latch = 1'b0, sel_brightness = 1'b0;
  logic          serial_data_in_red = 1'b0, serial_data_in_green = 1'b0, serial_data_in_blue = 1'b0;
  logic [W-1:0]  vals_red, vals_green, vals_blue;
  logic [BB-1:0] brightness;
  logic          vals_valid, bright_valid, frame_err;
  logic [4:0]    bit_count;

  int checks = 0;
  int failures = 0;

  // Reference model: words hold the last W bits received, n counts shifts unsaturated.
  int unsigned m_r, m_g, m_b, m_vr, m_vg, m_vb, m_br;
  int          m_n;
  logic        m_vv, m_bv, m_err;

  typedef struct {
    logic rs, sh, la, sel, r, g, b;
  } op_t;

  panel_receiver #(.WIDTH(W), .BRIGHT_BITS(BB)) dut (
    .clk(clk), .reset(reset), .shift(shift), .latch(latch),
    .sel_brightness(sel_brightness),
    .serial_data_in_red(serial_data_in_red),
    .serial_data_in_green(serial_data_in_green),
    .serial_data_in_blue(serial_data_in_blue),
    .vals_red(vals_red), .vals_green(vals_green), .vals_blue(vals_blue),
    .brightness(brightness), .vals_valid(vals_valid), .bright_valid(bright_valid),
    .frame_err(frame_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (reset) begin
      m_r = 0; m_g = 0; m_b = 0; m_n = 0;
      m_vr = 0; m_vg = 0; m_vb = 0; m_br = 0;
      m_vv = 0; m_bv = 0; m_err = 0;
    end else begin
      m_vv = 0; m_bv = 0;
      if (shift) begin
        m_r = (m_r * 2 + serial_data_in_red) % (1 << W);
        m_g = (m_g * 2 + serial_data_in_green) % (1 << W);
        m_b = (m_b * 2 + serial_data_in_blue) % (1 << W);
        m_n++;
      end
      if (latch) begin
        if (m_n != W) m_err = 1;
        else if (!sel_brightness) begin
          m_vr = m_r; m_vg = m_g; m_vb = m_b; m_vv = 1;
        end else if (m_r / (1 << BB) != 0) m_err = 1;
        else begin
          m_br = m_r; m_bv = 1;
        end
        m_r = 0; m_g = 0; m_b = 0; m_n = 0;
      end
    end
  endtask

  task automatic step(input logic rs, sh, la, sel, r, g, b);
    @(negedge clk);
    reset = rs; shift = sh; latch = la; sel_brightness = sel;
    serial_data_in_red = r; serial_data_in_green = g; serial_data_in_blue = b;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_bits(input int n, input logic [31:0] r, g, b);
    for (int i = n - 1; i >= 0; i--) step(0, 1, 0, 0, r[i], g[i], b[i]);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 0, 1, 1, 1);
    checks++;
    if ({vals_red, vals_green, vals_blue, brightness, vals_valid, bright_valid, frame_err, bit_count} !== '0) begin
      failures++;
      $display("FAIL reset_state: got r=%h g=%h b=%h br=%h vv=%b bv=%b err=%b cnt=%0d required all zero",
               vals_red, vals_green, vals_blue, brightness, vals_valid, bright_valid, frame_err, bit_count);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    send_bits(3, 32'h7, 32'h0, 32'h5);
    checks++;
    if (bit_count !== 5'd3) begin
      failures++; $display("FAIL count_after_3: got %0d required 3", bit_count);
    end
    step(1, 1, 0, 0, 1, 1, 1);
    checks++;
    if (bit_count !== 5'd0) begin
      failures++; $display("FAIL reset_clears_count: got %0d required 0", bit_count);
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_led_frame();
    send_bits(16, 32'hAAAA, 32'h5555, 32'hFFFF);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({vals_red, vals_green, vals_blue, vals_valid, bright_valid} !== {16'hAAAA, 16'h5555, 16'hFFFF, 2'b10}) begin
      failures++;
      $display("FAIL led_commit: got %h/%h/%h vv=%b bv=%b required AAAA/5555/FFFF vv=1 bv=0",
               vals_red, vals_green, vals_blue, vals_valid, bright_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (vals_valid !== 1'b0 || vals_red !== 16'hAAAA) begin
      failures++;
      $display("FAIL led_pulse_width: got vv=%b red=%h required vv=0 red=AAAA", vals_valid, vals_red);
    end
  endtask

  task automatic test_brightness();
    send_bits(16, 32'h00C3, $urandom, $urandom);
    step(0, 0, 1, 1, 0, 0, 0);
    checks++;
    if ({brightness, bright_valid, vals_valid, frame_err, vals_red, vals_green, vals_blue} !==
        {8'hC3, 3'b100, 16'hAAAA, 16'h5555, 16'hFFFF}) begin
      failures++;
      $display("FAIL bright_commit: got br=%h bv=%b vv=%b err=%b vals=%h/%h/%h required br=C3 bv=1 vv=0 err=0 vals=AAAA/5555/FFFF",
               brightness, bright_valid, vals_valid, frame_err, vals_red, vals_green, vals_blue);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bright_valid !== 1'b0 || brightness !== 8'hC3) begin
      failures++;
      $display("FAIL bright_pulse_width: got bv=%b br=%h required bv=0 br=C3", bright_valid, brightness);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(8, 32'hFF, 32'hFF, 32'hFF);
    step(1, 1, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    send_bits(16, 32'h1234, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (vals_red !== 16'h1234 || frame_err !== 1'b0 || vals_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_midframe: got red=%h err=%b vv=%b required red=1234 err=0 vv=1",
               vals_red, frame_err, vals_valid);
    end
  endtask

  task automatic test_bad_brightness();
    send_bits(16, 32'h01C3, 32'h0, 32'h0);
    step(0, 0, 1, 1, 0, 0, 0);
    checks++;
    if (frame_err !== 1'b1 || bright_valid !== 1'b0 || brightness !== 8'h00) begin
      failures++;
      $display("FAIL bad_brightness: got err=%b bv=%b br=%h required err=1 bv=0 br=00",
               frame_err, bright_valid, brightness);
    end
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_short_frame();
    logic [31:0] r, g, b;
    send_bits(15, 32'h7FFF, 32'h0, 32'h1);
    checks++;
    if (bit_count !== 5'd15) begin
      failures++; $display("FAIL short_count: got %0d required 15", bit_count);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (vals_valid !== 1'b0 || bright_valid !== 1'b0 || frame_err !== 1'b1 || bit_count !== 5'd0 || vals_red !== 16'h1234) begin
      failures++;
      $display("FAIL short_frame: got vv=%b bv=%b err=%b cnt=%0d red=%h required vv=0 bv=0 err=1 cnt=0 red=1234",
               vals_valid, bright_valid, frame_err, bit_count, vals_red);
    end
    r = $urandom_range(0, 16'hFFFF); g = $urandom_range(0, 16'hFFFF); b = $urandom_range(0, 16'hFFFF);
    send_bits(16, r, g, b);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({vals_red, vals_green, vals_blue, vals_valid, frame_err} !== {r[15:0], g[15:0], b[15:0], 2'b11}) begin
      failures++;
      $display("FAIL good_after_err: got %h/%h/%h vv=%b err=%b required %h/%h/%h vv=1 err=1",
               vals_red, vals_green, vals_blue, vals_valid, frame_err, r[15:0], g[15:0], b[15:0]);
    end
  endtask

  task automatic test_over_frame();
    logic [15:0] pr, pg, pb;
    pr = vals_red; pg = vals_green; pb = vals_blue;
    send_bits(1, 32'h1, 32'h1, 32'h1);
    send_bits(16, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    checks++;
    if (bit_count !== 5'd16) begin
      failures++; $display("FAIL over_saturate: got %0d required 16", bit_count);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({vals_red, vals_green, vals_blue, vals_valid, frame_err, bit_count} !== {pr, pg, pb, 2'b01, 5'd0}) begin
      failures++;
      $display("FAIL over_frame: got %h/%h/%h vv=%b err=%b cnt=%0d required %h/%h/%h vv=0 err=1 cnt=0",
               vals_red, vals_green, vals_blue, vals_valid, frame_err, bit_count, pr, pg, pb);
    end
    send_bits(16, 32'h0F0F, 32'hF0F0, 32'h3C3C);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({vals_red, vals_green, vals_blue, vals_valid} !== {16'h0F0F, 16'hF0F0, 16'h3C3C, 1'b1}) begin
      failures++;
      $display("FAIL idle_after_over: got %h/%h/%h vv=%b required 0F0F/F0F0/3C3C vv=1",
               vals_red, vals_green, vals_blue, vals_valid);
    end
  endtask

  task automatic test_shift_latch_same();
    logic [31:0] r, g, b;
    r = 32'hBEEF; g = 32'h1357; b = 32'h2468;
    send_bits(15, r >> 1, g >> 1, b >> 1);
    step(0, 1, 1, 0, r[0], g[0], b[0]);
    checks++;
    if ({vals_red, vals_green, vals_blue, vals_valid, bit_count} !== {16'hBEEF, 16'h1357, 16'h2468, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL shift_latch_same: got %h/%h/%h vv=%b cnt=%0d required BEEF/1357/2468 vv=1 cnt=0",
               vals_red, vals_green, vals_blue, vals_valid, bit_count);
    end
  endtask

  task automatic test_random();
    op_t ops[$];
    op_t o;
    int  len, expc;
    logic sel, merge;
    logic [31:0] r, g, b;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(W - 2, W + 2);
      sel = 1'($urandom_range(0, 1));
      merge = 1'($urandom_range(0, 1));
      r = $urandom; g = $urandom; b = $urandom;
      if (sel && $urandom_range(0, 2) != 0) r = r % 256;
      ops.delete();
      for (int i = len - 1; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) begin
          o = '{rs: 0, sh: 0, la: 0, sel: 1'($urandom_range(0, 1)), r: 1'($urandom_range(0, 1)),
                g: 1'($urandom_range(0, 1)), b: 1'($urandom_range(0, 1))};
          ops.push_back(o);
        end
        o = '{rs: ($urandom_range(0, 199) == 0), sh: 1, la: (i == 0 && merge), sel: sel,
              r: r[i % 32], g: g[i % 32], b: b[i % 32]};
        ops.push_back(o);
      end
      if (!merge) begin
        o = '{rs: 0, sh: 0, la: 1, sel: sel, r: 0, g: 0, b: 0};
        ops.push_back(o);
      end
      foreach (ops[k]) begin
        step(ops[k].rs, ops[k].sh, ops[k].la, ops[k].sel, ops[k].r, ops[k].g, ops[k].b);
        expc = (m_n > W) ? W : m_n;
        checks++;
        if ({vals_red, vals_green, vals_blue, brightness, vals_valid, bright_valid, frame_err, bit_count} !==
            {16'(m_vr), 16'(m_vg), 16'(m_vb), 8'(m_br), m_vv, m_bv, m_err, 5'(expc)}) begin
          failures++;
          $display("FAIL random_f%0d_c%0d: got %h/%h/%h br=%h vv=%b bv=%b err=%b cnt=%0d required %h/%h/%h br=%h vv=%b bv=%b err=%b cnt=%0d",
                   f, k, vals_red, vals_green, vals_blue, brightness, vals_valid, bright_valid, frame_err, bit_count,
                   16'(m_vr), 16'(m_vg), 16'(m_vb), 8'(m_br), m_vv, m_bv, m_err, expc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_led_frame();
    test_brightness();
    test_reset_midframe();
    test_short_frame();
    test_over_frame();
    test_shift_latch_same();
    step(1, 0, 0, 0, 0, 0, 0);
    test_bad_brightness();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
